// File: rtl/freqdiv_ctrl.sv
// Runtime-programmable clock divider: owns one registered divided clock and applies
// new ratios, start and stop only on period boundaries so clk_out never has a runt pulse.
module freqdiv_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             wrap;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half;

    // A ratio can only be queued while nothing is pending; the slot frees at the applying wrap.
    assign cfg_ready = !pend_v_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign wrap      = (cnt_q == div_q - ONE);
    assign cnt_inc   = cnt_q + ONE;
    assign half      = div_q >> 1;

    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign cur_div   = div_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_v_d   = pend_v_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;

        // Accepted ratios load directly when idle, otherwise wait for the next wrap.
        if (xfer) begin
            if (cfg_div < DIV_MIN) begin
                err_d = 1'b1;
            end else if (state_q == IDLE) begin
                div_d = cfg_div;
            end else begin
                pend_div_d = cfg_div;
                pend_v_d   = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                clk_out_d = 1'b0;
                if (run) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end

            RUN, STOPPING: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (pend_v_q) begin
                        div_d    = pend_div_q;
                        pend_v_d = 1'b0;
                    end
                    if (state_q == STOPPING && !run) begin
                        state_d   = IDLE;
                        clk_out_d = 1'b0;
                    end else begin
                        state_d   = run ? RUN : STOPPING;
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                    end
                end else begin
                    // STOPPING keeps counting so the last low phase is full length.
                    cnt_d     = cnt_inc;
                    clk_out_d = (cnt_inc < half);
                    state_d   = run ? RUN : STOPPING;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_RESET;
            pend_div_q <= DIV_RESET;
            pend_v_q   <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_v_q   <= pend_v_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_freqdiv_ctrl.sv
// Directed bench for freqdiv_ctrl: start, stop, restart, boundary ratio changes,
// rejected ratios and asynchronous reset with a pending ratio.
module tb_freqdiv_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             run;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] cur_div;
    logic             err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    freqdiv_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // n running cycles at ratio div, first cycle at phase phase0 of the period.
    task automatic periods(input string tag, input int n, input int div, input int phase0,
                           input logic rdy, input int cur);
        for (int i = 0; i < n; i++) begin
            int ph;
            cyc();
            ph = (phase0 + i) % div;
            check({tag, ".clk_out"}, 32'(clk_out), 32'(ph < div / 2));
            check({tag, ".tick"}, 32'(tick), 32'(ph == 0));
            check({tag, ".ready"}, 32'(cfg_ready), 32'(rdy));
            check({tag, ".cur_div"}, 32'(cur_div), 32'(cur));
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".err"}, 32'(err), 32'd0);
        end
    endtask

    task automatic idle_check(input string tag, input int cur);
        check({tag, ".clk_out"}, 32'(clk_out), 32'd0);
        check({tag, ".tick"}, 32'(tick), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".ready"}, 32'(cfg_ready), 32'd1);
        check({tag, ".cur_div"}, 32'(cur_div), 32'(cur));
    endtask

    task automatic load_idle(input logic [WIDTH-1:0] d);
        cfg_div   = d;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        idle_check("load", int'(d));
    endtask

    initial begin
        reset     = 1'b0;
        run       = 1'b0;
        cfg_div   = '0;
        cfg_valid = 1'b0;

        // Reset and idle
        repeat (3) cyc();
        idle_check("in_reset", 2);
        check("in_reset.err", 32'(err), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            idle_check("idle", 2);
        end

        // Ratio 4: 1,1,0,0 x3, then stop from the wrap edge finishes one full period
        load_idle(8'd4);
        run = 1'b1;
        periods("div4", 12, 4, 0, 1'b1, 4);
        run = 1'b0;
        periods("div4_stop", 4, 4, 0, 1'b1, 4);
        cyc();
        idle_check("div4_idle", 4);

        // Ratio 3: 1,0,0 x3
        load_idle(8'd3);
        run = 1'b1;
        periods("div3", 9, 3, 0, 1'b1, 3);
        run = 1'b0;
        periods("div3_stop", 3, 3, 0, 1'b1, 3);
        cyc();
        idle_check("div3_idle", 3);

        // Ratio change 4 -> 6 requested at cnt = 1
        load_idle(8'd4);
        run = 1'b1;
        periods("chg_a", 2, 4, 0, 1'b1, 4);
        cfg_div   = 8'd6;
        cfg_valid = 1'b1;
        periods("chg_xfer", 1, 4, 2, 1'b0, 4);
        cfg_valid = 1'b0;
        periods("chg_old4", 1, 4, 3, 1'b0, 4);
        periods("chg_new6", 12, 6, 0, 1'b1, 6);

        // Transfer 4 on a wrap edge: one further period of 6 before 4 applies
        cfg_div   = 8'd4;
        cfg_valid = 1'b1;
        periods("wrap_xfer", 1, 6, 0, 1'b0, 6);
        cfg_valid = 1'b0;
        periods("wrap_old6", 5, 6, 1, 1'b0, 6);
        periods("wrap_new4", 8, 4, 0, 1'b1, 4);

        // Rejected ratios 1 and 0 while running at 4
        cfg_div   = 8'd1;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        check("inv1.err", 32'(err), 32'd1);
        check("inv1.cur_div", 32'(cur_div), 32'd4);
        check("inv1.ready", 32'(cfg_ready), 32'd1);
        check("inv1.clk_out", 32'(clk_out), 32'd1);
        check("inv1.tick", 32'(tick), 32'd1);
        periods("inv1_after", 3, 4, 1, 1'b1, 4);
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        check("inv0.err", 32'(err), 32'd1);
        check("inv0.cur_div", 32'(cur_div), 32'd4);
        check("inv0.clk_out", 32'(clk_out), 32'd1);
        check("inv0.tick", 32'(tick), 32'd1);
        periods("inv0_after", 7, 4, 1, 1'b1, 4);

        // Move to ratio 5 via another wrap-edge transfer
        cfg_div   = 8'd5;
        cfg_valid = 1'b1;
        periods("x5_xfer", 1, 4, 0, 1'b0, 4);
        cfg_valid = 1'b0;
        periods("x5_old4", 3, 4, 1, 1'b0, 4);
        periods("x5_new5", 10, 5, 0, 1'b1, 5);

        // Stop at 5 with run dropped at cnt = 2
        periods("stop5_a", 3, 5, 0, 1'b1, 5);
        run = 1'b0;
        periods("stop5_tail", 2, 5, 3, 1'b1, 5);
        cyc();
        idle_check("stop5_idle", 5);
        for (int i = 0; i < 3; i++) begin
            cyc();
            idle_check("stop5_stay", 5);
        end

        // Restart, drop run, re-raise during STOPPING: no gap in the sequence
        run = 1'b1;
        periods("rs_a", 3, 5, 0, 1'b1, 5);
        run = 1'b0;
        periods("rs_stopping", 1, 5, 3, 1'b1, 5);
        run = 1'b1;
        periods("rs_resume", 7, 5, 4, 1'b1, 5);

        // Async reset mid high phase with a ratio pending
        cfg_div   = 8'd7;
        cfg_valid = 1'b1;
        periods("ar_xfer", 1, 5, 1, 1'b0, 5);
        cfg_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        idle_check("ar_async", 2);
        run = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        idle_check("ar_release", 2);
        run = 1'b1;
        periods("ar_div2", 4, 2, 0, 1'b1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freqdiv_ctrl.md
# freqdiv_ctrl

Runtime-programmable frequency-divider controller that owns one divided-clock output and sequences its start, stop and ratio changes. New divide ratios arrive over a valid/ready handshake and take effect only on a period boundary, so `clk_out` never has a runt pulse. The block sits between the register/config logic and the consumers of divided clocks. It replaces fixed-ratio `freqdiv` instances where the ratio must change at run time.

## Interface

- `WIDTH`, 8: width of the divide ratio and internal counter; maximum ratio is 2^WIDTH-1.
- `DEFAULT_DIV`, 2: ratio loaded at reset; must be >= 2 and < 2^WIDTH.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `run`  in  1  level enable; 1 = produce `clk_out`, 0 = stop at the end of the current period.
- `cfg_div`  in  WIDTH  requested divide ratio.
- `cfg_valid`  in  1  `cfg_div` is valid; transfer occurs when `cfg_valid & cfg_ready` at a rising edge.
- `cfg_ready`  out  1  block can accept a ratio.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-`clk`-cycle pulse coincident with each rising edge of `clk_out`.
- `cur_div`  out  WIDTH  ratio currently in effect.
- `err`  out  1  one-cycle pulse when a rejected ratio (< 2) is transferred.
- `busy`  out  1  1 when state is RUN or STOPPING.

## Operation

- State: `state` (IDLE/RUN/STOPPING), `cnt[WIDTH]`, `div_q` (drives `cur_div`), `pend_div`, `pend_v`.
- Reset values, applied asynchronously:
  - IDLE, `cnt` = 0, `div_q` = DEFAULT_DIV, `pend_v` = 0.
  - `clk_out` = 0, `tick` = 0, `err` = 0, `busy` = 0.
  - `cfg_ready` = 1.
- `cfg_ready` = `!pend_v`, combinational. In IDLE `pend_v` is always 0.
- Config transfer:
  - If `cfg_div` < 2: the value is dropped and `err` = 1 on the next cycle. `div_q` and `pend_v` are unchanged.
  - IDLE, valid ratio: `div_q` <= `cfg_div` on that edge.
  - RUN/STOPPING, valid ratio: `pend_div` <= `cfg_div`, `pend_v` <= 1.
- Period: `cnt` counts 0 .. `div_q`-1. `clk_out` is 1 while `cnt` < `div_q`>>1, otherwise 0.
  - `div_q` = 4 gives 1,1,0,0.
  - `div_q` = 3 gives 1,0,0 (odd ratios are low-biased).
- Wrap: the edge where `cnt` == `div_q`-1.
- Transitions, all on rising `clk`:
  - IDLE, `run` = 1 → RUN: `cnt` <= 0, `clk_out` <= 1, `tick` <= 1.
  - RUN, not wrap: `cnt` <= `cnt`+1; `clk_out` follows the rule above for the new `cnt`.
  - RUN, wrap: `cnt` <= 0, `clk_out` <= 1, `tick` <= 1. If `pend_v`: `div_q` <= `pend_div`, `pend_v` <= 0.
  - Wrap uses the old `div_q`. The new ratio governs the period beginning at this edge.
  - RUN, `run` = 0 → STOPPING. The counter advances exactly as in RUN.
  - STOPPING, `run` = 1 → RUN with no gap or phase change.
  - STOPPING, wrap with `run` = 0 → IDLE: `cnt` <= 0, `clk_out` <= 0, no tick, pending ratio applied.
  - STOPPING, wrap with `run` = 1 → RUN, normal wrap.
- Simultaneous events:
  - A transfer on a wrap edge goes to `pend_div`. It applies at the next wrap, not this one.
  - A transfer while `pend_v` = 1 cannot occur, because `cfg_ready` = 0.
- Reset mid-period: `clk_out` drops to 0 immediately. The pending ratio is discarded and `div_q` returns to DEFAULT_DIV.

## Timing

- Start latency: `run` sampled high at edge E0 gives `clk_out` = 1 and `tick` = 1 after E0.
- `clk_out` period is exactly `div_q` `clk` cycles. High phase is floor(`div_q`/2) cycles.
- `tick` is high only in the first `clk` cycle of each `clk_out` period.
- Stop latency: `clk_out` completes the current full period. The last low phase is full length.
- Ratio change latency: takes effect at the first wrap strictly after the transfer edge. Max 2 periods of the old ratio.
- `cfg_ready` returns to 1 the cycle after the applying wrap.
- `busy` = 1 from the edge entering RUN through the cycle before IDLE.

## Test plan

- Reset and idle:
  - Hold `reset` = 0, then release with `run` = 0 for 10 cycles.
  - Required: `clk_out` = 0, `tick` = 0, `cur_div` = 2, `cfg_ready` = 1, `busy` = 0.
- Basic division:
  - In IDLE transfer `cfg_div` = 4, then `run` = 1 for 12 cycles.
  - Required: `clk_out` = 1,1,0,0 ×3 and `tick` at cycles 0, 4, 8.
  - Repeat with `cfg_div` = 3. Required: `clk_out` = 1,0,0.
- Boundary ratio change:
  - Running at 4, transfer 6 at `cnt` = 1. Required: `cfg_ready` = 0 until the wrap; the current period stays at 4 cycles; the following periods are 6 (1,1,1,0,0,0).
  - Repeat with the transfer on a wrap edge. Required: one further period of 4.
- Invalid ratio:
  - Transfer `cfg_div` = 1, and separately 0, while running at 4.
  - Required: `err` pulses one cycle, `cur_div` stays 4, no period disturbance.
- Stop/restart:
  - Running at 5, drop `run` at `cnt` = 2. Required: `clk_out` finishes the period, then stays 0 and `busy` = 0.
  - Re-raise `run` during STOPPING. Required: no gap in the period sequence.
- Async reset mid-period:
  - Assert `reset` = 0 between `clk` edges while `clk_out` = 1 and a pending ratio exists.
  - Required: `clk_out` falls before the next edge; after release, `cur_div` = 2 and `pend_v` = 0.
